muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit with HI/LO registers for MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
//   Sits beside the ALU: operands come from gpr_read_data_1/_2.
//   hi/lo feed gpr_write_mux as an extra source.
//   busy goes to controller/ifu to stall the PC while an operation runs.
// PARAMETERS
//   WIDTH  32  operand / HI / LO width; iteration count equals WIDTH
// PORTS
//   clk    in   1      system clock, rising edge
//   rst    in   1      synchronous, active-low reset
//   start  in   1      launch operation in op; sampled only when busy=0
//   op     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a      in   WIDTH  rs operand (multiplicand / dividend)
//   b      in   WIDTH  rt operand (multiplier / divisor)
//   hi_we  in   1      MTHI: hi <= wdata
//   lo_we  in   1      MTLO: lo <= wdata
//   wdata  in   WIDTH  data for MTHI/MTLO
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse: hi/lo just updated by an operation
//   hi     out  WIDTH  HI register (product high / remainder)
//   lo     out  WIDTH  LO register (product low / quotient)
// BEHAVIOUR
// - Reset (rst=0 at an edge): hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0.
//   Takes effect mid-operation: the operation is abandoned and no done follows.
// - FSM IDLE -> RUN when start=1 at an edge.
//   At that edge, latch |a| and |b| (signed ops take magnitudes), the result sign and the dividend sign; counter=0.
// - RUN: one step per edge, counter+1.
//   - MUL: shift-add, 2*WIDTH accumulator.
//   - DIV: restoring, WIDTH+1-bit partial remainder.
// - Step WIDTH (counter==WIDTH-1) is the final edge. At that edge:
//   - sign-correct the result;
//   - write hi and lo;
//   - done=1, busy=0;
//   - FSM -> IDLE.
// - Latency: start sampled at edge N -> busy=1 after N..N+WIDTH-1; hi/lo/done valid after edge N+WIDTH.
//   done lasts exactly one cycle. WIDTH=32 gives 32 cycles.
// - busy is registered and is 1 exactly while FSM=RUN. done=0 at every other edge.
// - Signed results:
//   - MULT: negate the 64-bit product if the signs differ.
//   - DIV: quotient negative if the signs differ; remainder takes the sign of the dividend.
// - DIV -2^31 / -1: lo=0x8000_0000, hi=0 (wraps, no trap).
// - Divide by zero (DIV/DIVU): lo=all ones, hi=a (unmodified dividend), same latency.
// - start while busy=1: ignored, no queueing.
// - hi_we/lo_we while busy=1, or together with start in IDLE: ignored (start wins).
// - hi_we and lo_we together in IDLE: both written, same cycle.
// - Write takes effect at the edge; hi/lo visible the next cycle.
// - hi/lo hold the previous values throughout RUN; MFHI/MFLO during busy read stale data.
//   The controller must stall on busy, so this case never reaches the GPR.
// TESTING
// - MULTU a=FFFF_FFFF b=FFFF_FFFF -> after 32 cycles done=1, hi=FFFF_FFFE, lo=0000_0001.
//   busy high for exactly 32 cycles.
// - MULT a=FFFF_FFFD(-3) b=0000_0007 -> hi=FFFF_FFFF, lo=FFFF_FFEB (-21).
// - DIV a=FFFF_FFF9(-7) b=2 -> lo=FFFF_FFFD, hi=FFFF_FFFF.
//   DIVU a=100 b=7 -> lo=14, hi=2.
// - DIVU a=5 b=0 -> lo=FFFF_FFFF, hi=5, done at 32 cycles.
//   DIV a=8000_0000 b=FFFF_FFFF -> lo=8000_0000, hi=0.
// - Start MULTU; pulse start (DIVU) and hi_we (wdata=1234) at cycle 5.
//   Both ignored; original product appears; hi_we in IDLE then sets hi=1234.
// - Start DIV; rst=0 at cycle 10 -> next cycle busy=0, hi=lo=0.
//   No done pulse within the following 40 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; one shift-add or
// restoring-divide step per cycle, WIDTH cycles per operation.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic               is_div, neg_res, neg_rem, div_zero;
  logic [WIDTH-1:0]   opnd;      // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0]   dvd_raw;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] acc;       // MUL: {partial, multiplier}; DIV: low half = dividend/quotient

  logic               sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               last;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx, prod;
  logic [WIDTH:0]     div_sh, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem_nx, div_quo_nx, quo_s, rem_s;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign sgn   = ~op[0];
  assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;
  assign last  = (state == RUN) && (cnt == CW'(WIDTH-1));
  assign busy  = (state == RUN);

  always_comb begin
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nx     = {mul_sum, acc[WIDTH-1:1]};
    div_sh     = {rem, acc[WIDTH-1]};
    div_diff   = div_sh - {1'b0, opnd};
    // A borrow out of the WIDTH+1-bit subtract means the trial failed: restore.
    div_ge     = ~div_diff[WIDTH];
    div_rem_nx = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_quo_nx = {acc[WIDTH-2:0], div_ge};

    prod  = neg_res ? -mul_nx : mul_nx;
    quo_s = neg_res ? -div_quo_nx : div_quo_nx;
    rem_s = neg_rem ? -div_rem_nx : div_rem_nx;

    if (!is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (div_zero) begin
      res_hi = dvd_raw;
      res_lo = '1;
    end else begin
      res_hi = rem_s;
      res_lo = quo_s;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      rem      <= '0;
      opnd     <= '0;
      dvd_raw  <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          cnt      <= '0;
          is_div   <= op[1];
          neg_res  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem  <= sgn && a[WIDTH-1];
          div_zero <= (b == '0);
          dvd_raw  <= a;
          rem      <= '0;
          opnd     <= op[1] ? mag_b : mag_a;
          acc      <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
        end else begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
        end
      end else begin
        cnt <= cnt + CW'(1);
        if (is_div) begin
          acc[WIDTH-1:0] <= div_quo_nx;
          rem            <= div_rem_nx;
        end else begin
          acc <= mul_nx;
        end
        if (last) begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table + random ops checked via a scoreboard
// queue, plus hand sequences for busy-time writes/starts and mid-op reset.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0, rst = 1'b0, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_chk = 0, n_fail = 0;

  typedef struct {logic [1:0] op; logic [W-1:0] a, b, eh, el;} vec_t;
  typedef struct {logic [W-1:0] eh, el; string name;} exp_t;
  exp_t sb[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(logic [1:0] mop, logic [31:0] ma, logic [31:0] mb);
    longint da, db, p, q, r;
    logic [63:0] up;
    if (mop[1] && mb == 32'd0) return {ma, 32'hFFFF_FFFF};
    case (mop)
      2'd0: begin
        p = longint'($signed(ma)) * longint'($signed(mb));
        return p;
      end
      2'd1: begin
        up = {32'd0, ma} * {32'd0, mb};
        return up;
      end
      2'd2: begin
        da = longint'($signed(ma));
        db = longint'($signed(mb));
        q = da / db;
        r = da % db;
        return {r[31:0], q[31:0]};
      end
      default: return {ma % mb, ma / mb};
    endcase
  endfunction

  task automatic launch(logic [1:0] top, logic [W-1:0] ta, logic [W-1:0] tb_);
    op = top; a = ta; b = tb_; start = 1'b1;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  // Wait for done; cyc0 edges since launch already elapsed with busy seen high.
  task automatic finish_op(string name, int cyc0);
    int cyc, nb;
    exp_t e;
    cyc = cyc0; nb = cyc0;
    while (!done && cyc < 100) begin
      if (busy) nb++;
      tick();
      cyc++;
    end
    chk({name, " done"}, done, 1);
    chk({name, " latency"}, cyc, 32);
    chk({name, " busy cycles"}, nb, 32);
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.name, " hi"}, hi, e.eh);
      chk({e.name, " lo"}, lo, e.el);
    end
    tick();
    chk({name, " done pulse"}, done, 0);
    chk({name, " busy drop"}, busy, 0);
  endtask

  task automatic run_op(logic [1:0] top, logic [W-1:0] ta, logic [W-1:0] tb_,
                        logic [W-1:0] eh, logic [W-1:0] el, string name);
    sb.push_back('{eh, el, name});
    launch(top, ta, tb_);
    finish_op(name, 0);
  endtask

  initial begin
    vec_t vt[9];
    logic [63:0] m;
    logic [1:0] rop;
    logic [W-1:0] ra, rb, hold_hi;
    int ndone;

    vt[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vt[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vt[2] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3] = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14};
    vt[4] = '{2'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vt[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vt[6] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vt[7] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vt[8] = '{2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};

    // Reset state
    tick(); tick();
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    rst = 1'b1;
    tick();

    // MTHI+MTLO together, then MTLO alone
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0001;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi+mtlo hi", hi, 32'hA5A5_0001);
    chk("mthi+mtlo lo", lo, 32'hA5A5_0001);
    lo_we = 1'b1; wdata = 32'h0000_0002;
    tick();
    lo_we = 1'b0;
    chk("mtlo lo", lo, 32'h0000_0002);
    chk("mtlo hi kept", hi, 32'hA5A5_0001);

    for (int i = 0; i < 9; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].eh, vt[i].el, $sformatf("vec%0d", i));

    // start together with hi_we in IDLE: start wins
    hi_we = 1'b1; wdata = 32'h5555_5555;
    run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, "start+mthi");

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 4 == 3) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 300)) : $urandom);
      m   = model(rop, ra, rb);
      run_op(rop, ra, rb, m[63:32], m[31:0], $sformatf("rnd%0d op%0d", i, rop));
    end

    // MULTU with a DIVU start and MTHI pulsed at cycle 5: both ignored
    hold_hi = hi;
    sb.push_back('{32'hFFFF_FFFE, 32'h0000_0001, "busy-ignore"});
    launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) tick();
    op = 2'd3; a = 32'd100; b = 32'd7; start = 1'b1; hi_we = 1'b1; wdata = 32'd1234;
    tick();
    start = 1'b0; hi_we = 1'b0;
    chk("busy-ignore busy c5", busy, 1);
    chk("busy-ignore hi stale", hi, {32'd0, hold_hi});
    finish_op("busy-ignore", 5);
    hi_we = 1'b1; wdata = 32'd1234;
    tick();
    hi_we = 1'b0;
    chk("idle mthi hi", hi, 32'd1234);
    chk("idle mthi lo kept", lo, 32'h0000_0001);

    // Reset in the middle of a DIV
    launch(2'd2, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midreset busy", busy, 0);
    chk("midreset hi", hi, 0);
    chk("midreset lo", lo, 0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("midreset no done", ndone, 0);
    chk("scoreboard drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
